fwd_scoreboard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined RV32I core. It selects operand bypass sources from NUM_FWD_STAGES writeback-capable stages for NUM_SRC source operands. It adds a per-register countdown scoreboard for multi-cycle and variable-latency units (mul/div) and load-use stall detection. It sits between ID/EX decode and the EX operand muxes and drives the pipeline stall line.

---
 rtl/fwd_scoreboard_unit_pkg.sv | 19 +
 rtl/fwd_scoreboard_unit_select.sv | 39 +++
 rtl/fwd_scoreboard_unit.sv | 113 +++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_unit_pkg.sv
// Shared constants and types for the forwarding / scoreboard unit.
// Holds the fwd_sel encoding and the scoreboard counter type.
package fwd_scoreboard_unit_pkg;

   localparam int DEF_REG_AW  = 5;
   localparam int DEF_MAX_LAT = 7;
   localparam int SB_CW       = $clog2(DEF_MAX_LAT + 1);

   // fwd_sel encoding: 0 reads the register file, stage k is encoded as k+1
   localparam int FWD_RF         = 0;
   localparam int FWD_STAGE_BASE = 1;

   typedef logic [SB_CW-1:0] sb_cnt_t;

   function automatic int fwd_stage_code(input int k);
      return k + FWD_STAGE_BASE;
   endfunction

endpackage

// File: rtl/fwd_scoreboard_unit_select.sv
// Per-source priority bypass selector: the youngest matching stage wins,
// and a match whose data is not ready flags a load-use hazard.
module fwd_scoreboard_unit_select
   import fwd_scoreboard_unit_pkg::*;
#(
   parameter int NUM_FWD_STAGES = 2,
   parameter int REG_AW         = DEF_REG_AW,
   parameter int SW             = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic [REG_AW-1:0]                src_addr,
   input  logic [NUM_FWD_STAGES-1:0]        stg_wr_en,
   input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
   input  logic [NUM_FWD_STAGES-1:0]        stg_data_vld,
   output logic [SW-1:0]                    sel,
   output logic                             hazard
);

   logic found;

   always_comb begin
      sel    = SW'(FWD_RF);
      hazard = 1'b0;
      found  = 1'b0;
      // Only the youngest match counts; an unready match never falls through
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
         if (!found && stg_wr_en[k] &&
             (stg_rd[k*REG_AW +: REG_AW] != '0) &&
             (stg_rd[k*REG_AW +: REG_AW] == src_addr)) begin
            found = 1'b1;
            if (stg_data_vld[k]) begin
               sel = SW'(fwd_stage_code(k));
            end else begin
               hazard = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Operand bypass selection, long-latency scoreboard and stall generation
// for the ID/EX boundary of the RV32I pipeline.
module fwd_scoreboard_unit
   import fwd_scoreboard_unit_pkg::*;
#(
   parameter int NUM_SRC        = 2,
   parameter int NUM_FWD_STAGES = 2,
   parameter int MAX_LAT        = DEF_MAX_LAT,
   parameter int REG_AW         = DEF_REG_AW,
   localparam int CW            = $clog2(MAX_LAT + 1),
   localparam int SW            = $clog2(NUM_FWD_STAGES + 1),
   localparam int NREG          = 2 ** REG_AW
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_SRC*REG_AW-1:0]        src_addr,
   input  logic [NUM_SRC-1:0]               src_used,
   input  logic [NUM_FWD_STAGES-1:0]        stg_wr_en,
   input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
   input  logic [NUM_FWD_STAGES-1:0]        stg_data_vld,
   input  logic                             iss_valid,
   input  logic [REG_AW-1:0]                iss_rd,
   input  logic [CW-1:0]                    iss_lat,
   input  logic                             done_valid,
   input  logic [REG_AW-1:0]                done_rd,
   input  logic                             flush,
   output logic [NUM_SRC*SW-1:0]            fwd_sel,
   output logic                             stall,
   output logic [NREG-1:0]                  sb_busy,
   output logic [15:0]                      stall_cnt
);

   logic [NUM_SRC-1:0] src_hazard;
   logic [NUM_SRC-1:0] src_stall;
   logic               waw_stall;
   logic               iss_accept;
   logic [15:0]        stall_cnt_reg;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [REG_AW-1:0] addr;
         logic [SW-1:0]     sel;

         assign addr = src_addr[gi*REG_AW +: REG_AW];

         fwd_scoreboard_unit_select #(
            .NUM_FWD_STAGES (NUM_FWD_STAGES),
            .REG_AW         (REG_AW),
            .SW             (SW)
         ) u_select (
            .src_addr     (addr),
            .stg_wr_en    (stg_wr_en),
            .stg_rd       (stg_rd),
            .stg_data_vld (stg_data_vld),
            .sel          (sel),
            .hazard       (src_hazard[gi])
         );

         assign fwd_sel[gi*SW +: SW] = sel;
         assign src_stall[gi] = src_used[gi] && (src_hazard[gi] || sb_busy[addr]);
      end
   endgenerate

   // A register released by done_valid this cycle is free for a new writer
   assign waw_stall  = iss_valid && sb_busy[iss_rd] &&
                       !(done_valid && (done_rd == iss_rd));
   assign stall      = (|src_stall) || waw_stall;
   assign iss_accept = iss_valid && !stall && (iss_rd != '0);

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
         if (gi == 0) begin : g_zero
            assign sb_busy[gi] = 1'b0;
         end else begin : g_reg
            logic [CW-1:0] cnt_reg;
            logic          pend_reg;

            always_ff @(posedge clk) begin
               if (rst || flush) begin
                  cnt_reg  <= '0;
                  pend_reg <= 1'b0;
               end else if (iss_accept && (iss_rd == REG_AW'(gi))) begin
                  if (iss_lat != '0) begin
                     cnt_reg  <= iss_lat;
                     pend_reg <= 1'b0;
                  end else begin
                     cnt_reg  <= '0;
                     pend_reg <= 1'b1;
                  end
               end else if (done_valid && (done_rd == REG_AW'(gi))) begin
                  cnt_reg  <= '0;
                  pend_reg <= 1'b0;
               end else if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end

            assign sb_busy[gi] = (cnt_reg != '0) || pend_reg;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed bench for fwd_scoreboard_unit: bypass priority, load-use,
// scoreboard latency/variable ops, WAW, flush and reset.
module tb_fwd_scoreboard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  src_addr;
   logic [1:0]  src_used;
   logic [1:0]  stg_wr_en;
   logic [9:0]  stg_rd;
   logic [1:0]  stg_data_vld;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [2:0]  iss_lat;
   logic        done_valid;
   logic [4:0]  done_rd;
   logic        flush;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic [31:0] sb_busy;
   logic [15:0] stall_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fwd_scoreboard_unit dut (
      .clk          (clk),
      .rst          (rst),
      .src_addr     (src_addr),
      .src_used     (src_used),
      .stg_wr_en    (stg_wr_en),
      .stg_rd       (stg_rd),
      .stg_data_vld (stg_data_vld),
      .iss_valid    (iss_valid),
      .iss_rd       (iss_rd),
      .iss_lat      (iss_lat),
      .done_valid   (done_valid),
      .done_rd      (done_rd),
      .flush        (flush),
      .fwd_sel      (fwd_sel),
      .stall        (stall),
      .sb_busy      (sb_busy),
      .stall_cnt    (stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle();
      src_addr = '0; src_used = '0; stg_wr_en = '0; stg_rd = '0; stg_data_vld = '0;
      iss_valid = 1'b0; iss_rd = '0; iss_lat = '0;
      done_valid = 1'b0; done_rd = '0; flush = 1'b0;
   endtask

   // Inputs change 1 time unit after the edge; outputs checked 1 unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset_fwd_sel", 32'(fwd_sel), 32'h0);
      chk("reset_stall", 32'(stall), 32'h0);
      chk("reset_sb_busy", sb_busy, 32'h0);
      chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);

      // both stages write x5, youngest wins; then only stage1 matches
      stg_wr_en = 2'b11; stg_data_vld = 2'b11; stg_rd = {5'd5, 5'd5};
      src_addr = {5'd0, 5'd5}; src_used = 2'b01;
      #1;
      chk("fwd_both_stages", 32'(fwd_sel[1:0]), 32'h1);
      chk("fwd_both_stall", 32'(stall), 32'h0);
      stg_rd = {5'd5, 5'd6};
      #1;
      chk("fwd_stage1", 32'(fwd_sel[1:0]), 32'h2);

      // x0 never forwards and never stalls
      stg_wr_en = 2'b01; stg_data_vld = 2'b00; stg_rd = '0; src_addr = '0; src_used = 2'b01;
      #1;
      chk("x0_fwd_sel", 32'(fwd_sel[1:0]), 32'h0);
      chk("x0_stall", 32'(stall), 32'h0);
      src_used = 2'b00;
      #1;
      chk("x0_unused_stall", 32'(stall), 32'h0);

      // unused source with an unready match does not stall
      stg_wr_en = 2'b11; stg_rd = {5'd9, 5'd9}; stg_data_vld = 2'b10;
      src_addr = {5'd9, 5'd0}; src_used = 2'b01;
      #1;
      chk("loaduse_unused_stall", 32'(stall), 32'h0);

      // load-use: unready stage0 blocks fall-through to ready stage1
      src_used = 2'b10;
      #1;
      chk("loaduse_fwd_sel", 32'(fwd_sel[3:2]), 32'h0);
      chk("loaduse_stall", 32'(stall), 32'h1);
      tick();
      stg_wr_en = 2'b10; stg_rd = {5'd9, 5'd0}; stg_data_vld = 2'b10;
      #1;
      chk("loaduse_after_fwd_sel", 32'(fwd_sel[3:2]), 32'h2);
      chk("loaduse_after_stall", 32'(stall), 32'h0);
      chk("loaduse_stall_cnt", 32'(stall_cnt), 32'h1);

      // fixed latency 3 on x7
      idle();
      iss_valid = 1'b1; iss_rd = 5'd7; iss_lat = 3'd3;
      #1;
      chk("lat3_issue_stall", 32'(stall), 32'h0);
      tick();
      idle();
      src_addr = {5'd0, 5'd7}; src_used = 2'b01;
      #1;
      chk("lat3_c1_stall", 32'(stall), 32'h1);
      chk("lat3_c1_busy", 32'(sb_busy[7]), 32'h1);
      tick();
      src_used = 2'b00; iss_valid = 1'b1; iss_rd = 5'd7; iss_lat = 3'd5;
      #1;
      chk("waw_stall", 32'(stall), 32'h1);
      tick();
      idle();
      src_addr = {5'd0, 5'd7}; src_used = 2'b01;
      #1;
      chk("lat3_c3_stall", 32'(stall), 32'h1);
      tick();
      #1;
      chk("lat3_c4_stall", 32'(stall), 32'h0);
      chk("lat3_c4_busy", sb_busy, 32'h0);
      chk("lat3_stall_cnt", 32'(stall_cnt), 32'h4);

      // variable latency on x12, held until done; reissue on the done cycle
      idle();
      iss_valid = 1'b1; iss_rd = 5'd12; iss_lat = 3'd0;
      tick();
      idle();
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("var_busy_c%0d", c), 32'(sb_busy[12]), 32'h1);
         tick();
      end
      done_valid = 1'b1; done_rd = 5'd12;
      iss_valid = 1'b1; iss_rd = 5'd12; iss_lat = 3'd2;
      #1;
      chk("reissue_stall", 32'(stall), 32'h0);
      tick();
      idle();
      chk("reissue_busy_c1", 32'(sb_busy[12]), 32'h1);
      tick();
      chk("reissue_busy_c2", 32'(sb_busy[12]), 32'h1);
      tick();
      chk("reissue_busy_c3", 32'(sb_busy[12]), 32'h0);

      // flush beats an in-flight op and a same-cycle issue
      iss_valid = 1'b1; iss_rd = 5'd3; iss_lat = 3'd5;
      tick();
      idle();
      tick();
      chk("flush_pre_busy", 32'(sb_busy[3]), 32'h1);
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4; iss_lat = 3'd3;
      tick();
      idle();
      chk("flush_sb_busy", sb_busy, 32'h0);
      chk("flush_stall_cnt", 32'(stall_cnt), 32'h4);

      // reset mid-operation
      iss_valid = 1'b1; iss_rd = 5'd8; iss_lat = 3'd7;
      tick();
      idle();
      src_addr = {5'd0, 5'd8}; src_used = 2'b01;
      #1;
      chk("midrst_stall", 32'(stall), 32'h1);
      tick();
      chk("midrst_pre_cnt", 32'(stall_cnt), 32'h5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      #1;
      chk("midrst_stall_cnt", 32'(stall_cnt), 32'h0);
      chk("midrst_sb_busy", sb_busy, 32'h0);
      chk("midrst_stall", 32'(stall), 32'h0);
      chk("midrst_fwd_sel", 32'(fwd_sel), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
